// File: rtl/sha256_padder_if.sv
// Byte-stream input, block output and core handshake bundle for the SHA-256 padder.
interface sha256_padder_if;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_start;
    logic         blk_first;
    logic         blk_final;
    logic         core_finish;
    logic         msg_done;

    modport slave (
        input  in_valid, in_data, in_last, in_empty, core_finish,
        output in_ready, blk_data, blk_start, blk_first, blk_final, msg_done
    );

    modport master (
        output in_valid, in_data, in_last, in_empty, core_finish,
        input  in_ready, blk_data, blk_start, blk_first, blk_final, msg_done
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message front-end: buffers bytes, applies padding plus 64-bit length and
// hands complete 512-bit blocks to the compression core one at a time.
module sha256_padder (
    input logic            clock,
    input logic            reset,
    sha256_padder_if.slave bus
);
    typedef enum logic [2:0] {StFill, StPad, StIssue, StWait, StLenblk} state_e;

    state_e       state_q, state_d;
    logic [511:0] data_q, data_d;
    logic [5:0]   ptr_q, ptr_d;
    logic [63:0]  bitlen_q, bitlen_d;
    logic         first_q, first_d;
    logic         pad_pend_q, pad_pend_d;
    logic         len_pend_q, len_pend_d;
    logic         final_q, final_d;
    logic         msg_done_q, msg_done_d;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        ptr_d      = ptr_q;
        bitlen_d   = bitlen_q;
        first_d    = first_q;
        pad_pend_d = pad_pend_q;
        len_pend_d = len_pend_q;
        final_d    = final_q;
        msg_done_d = 1'b0;

        unique case (state_q)
            StFill: begin
                if (bus.in_valid) begin
                    if (bus.in_last && bus.in_empty) begin
                        state_d = StPad;
                    end else begin
                        // Byte i sits at bits 8*(63-i), i.e. {~i, 3'b000}.
                        data_d[{~ptr_q, 3'b000} +: 8] = bus.in_data;
                        ptr_d    = ptr_q + 6'd1;
                        bitlen_d = bitlen_q + 64'd8;
                        if (ptr_q == 6'd63) begin
                            state_d    = StIssue;
                            final_d    = 1'b0;
                            pad_pend_d = bus.in_last;
                        end else if (bus.in_last) begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                for (int i = 0; i < 64; i++) begin
                    if (6'(i) == ptr_q) begin
                        data_d[8*(63-i) +: 8] = 8'h80;
                    end else if (6'(i) > ptr_q) begin
                        data_d[8*(63-i) +: 8] = 8'h00;
                    end
                end
                if (ptr_q <= 6'd55) begin
                    data_d[63:0] = bitlen_q;
                    final_d      = 1'b1;
                end else begin
                    // No room for the length: it goes into a block of its own.
                    len_pend_d = 1'b1;
                    final_d    = 1'b0;
                end
                state_d = StIssue;
            end
            StLenblk: begin
                data_d  = {448'd0, bitlen_q};
                final_d = 1'b1;
                state_d = StIssue;
            end
            StIssue: begin
                first_d = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                if (bus.core_finish) begin
                    if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        state_d    = StPad;
                    end else if (len_pend_q) begin
                        len_pend_d = 1'b0;
                        state_d    = StLenblk;
                    end else if (final_q) begin
                        msg_done_d = 1'b1;
                        bitlen_d   = '0;
                        ptr_d      = '0;
                        first_d    = 1'b1;
                        state_d    = StFill;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StFill;
            data_q     <= '0;
            ptr_q      <= '0;
            bitlen_q   <= '0;
            first_q    <= 1'b1;
            pad_pend_q <= 1'b0;
            len_pend_q <= 1'b0;
            final_q    <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            ptr_q      <= ptr_d;
            bitlen_q   <= bitlen_d;
            first_q    <= first_d;
            pad_pend_q <= pad_pend_d;
            len_pend_q <= len_pend_d;
            final_q    <= final_d;
            msg_done_q <= msg_done_d;
        end
    end

    // The buffer only changes in FILL/PAD/LENBLK, so it is stable from ISSUE through WAIT.
    assign bus.blk_data  = data_q;
    assign bus.in_ready  = (state_q == StFill);
    assign bus.blk_start = (state_q == StIssue);
    assign bus.blk_first = (state_q == StIssue) && first_q;
    assign bus.blk_final = (state_q == StIssue) && final_q;
    assign bus.msg_done  = msg_done_q;
endmodule

// File: tb/tb_sha256_padder.sv
// Randomized self-checking bench for sha256_padder: byte-level padding model plus a
// behavioural core that checks each block and answers with a random finish latency.
module tb_sha256_padder;
    logic clock;
    logic reset;

    sha256_padder_if bus ();

    sha256_padder dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    logic [7:0]   msg_q[$];
    logic [511:0] exp_blk[$];
    bit           exp_first[$];
    bit           exp_final[$];

    bit           busy, fin_pending, noise, cur_final, hold_core;
    int           delay, held_starts, msgs_done, msgs_sent;
    logic [511:0] cur_blk;

    int specials[12] = '{0, 1, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pad the whole message as a byte array, then cut it into 64-byte blocks.
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nblk;
        p    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            logic [511:0] blk;
            for (int k = 0; k < 64; k++) blk[511-8*k -: 8] = p[64*b+k];
            exp_blk.push_back(blk);
            exp_first.push_back(b == 0);
            exp_final.push_back(b == nblk - 1);
        end
        msgs_sent++;
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic last, input logic empty);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_empty = empty;
        @(negedge clock);
        while (!bus.in_ready && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1'b1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic send_msg();
        int n = msg_q.size();
        push_expected();
        if (n == 0) begin
            drive_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clock);
                    #1;
                end
                // in_empty on a non-last beat must be ignored.
                drive_beat(msg_q[k], k == n - 1, (k == n - 1) ? 1'b0 : 1'($urandom));
            end
        end
    endtask

    task automatic fill_msg(input int len, input logic [7:0] fixed, input bit rnd);
        msg_q.delete();
        for (int k = 0; k < len; k++) msg_q.push_back(rnd ? 8'($urandom) : fixed);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_blk.size() != 0 || busy || fin_pending) && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_blk.size() != 0 || busy) check("drain_timeout", exp_blk.size(), 0);
    endtask

    // Behavioural compression core.
    initial begin
        bus.core_finish = 1'b0;
        busy = 0; fin_pending = 0; noise = 0; cur_final = 0;
        held_starts = 0; msgs_done = 0;
        forever begin
            @(negedge clock);
            if (noise) begin
                bus.core_finish = 1'b0;
                noise = 0;
            end
            if (!reset) begin
                busy = 0;
                fin_pending = 0;
                bus.core_finish = 1'b0;
            end else if (fin_pending) begin
                bus.core_finish = 1'b0;
                fin_pending = 0;
                busy = 0;
                check("msg_done", bus.msg_done, cur_final);
                if (cur_final) msgs_done++;
            end else if (bus.blk_start) begin
                if (hold_core) begin
                    held_starts++;
                end else if (exp_blk.size() == 0) begin
                    check("spurious_start", bus.blk_start, 1'b0);
                end else begin
                    logic [511:0] e;
                    bit ef, el;
                    e  = exp_blk.pop_front();
                    ef = exp_first.pop_front();
                    el = exp_final.pop_front();
                    check("blk_data", bus.blk_data, e);
                    check("blk_first", bus.blk_first, ef);
                    check("blk_final", bus.blk_final, el);
                    check("msg_done_quiet", bus.msg_done, 1'b0);
                    cur_blk   = bus.blk_data;
                    cur_final = el;
                    busy      = 1;
                    delay     = $urandom_range(0, 6);
                end
            end else if (busy) begin
                if (delay == 0) begin
                    check("blk_hold", bus.blk_data, cur_blk);
                    check("flags_idle", {bus.blk_first, bus.blk_final}, 2'b00);
                    check("in_ready_wait", bus.in_ready, 1'b0);
                    bus.core_finish = 1'b1;
                    fin_pending = 1;
                end else begin
                    delay--;
                end
            end else if (!hold_core && $urandom_range(0, 7) == 0) begin
                // Stray finish while not in WAIT must be ignored.
                bus.core_finish = 1'b1;
                noise = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        reset        = 1'b0;
        hold_core    = 0;
        msgs_sent    = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        bus.in_empty = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_blk_data", bus.blk_data, 512'd0);
        check("rst_blk_start", bus.blk_start, 1'b0);
        check("rst_blk_first", bus.blk_first, 1'b0);
        check("rst_blk_final", bus.blk_final, 1'b0);
        check("rst_msg_done", bus.msg_done, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // "abc": PAD one cycle after the last accept, ISSUE the cycle after.
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg();
        @(negedge clock);
        check("abc_lat_pad", bus.blk_start, 1'b0);
        @(negedge clock);
        check("abc_lat_issue", bus.blk_start, 1'b1);
        check("abc_vector", bus.blk_data, {32'h61626380, 416'd0, 64'h18});
        wait_idle();

        fill_msg(55, 8'h00, 0); send_msg(); wait_idle();
        fill_msg(56, 8'h00, 0); send_msg(); wait_idle();

        // Full block: blk_start the cycle after the 64th byte.
        fill_msg(64, 8'h00, 1);
        send_msg();
        @(negedge clock);
        check("full_lat_issue", bus.blk_start, 1'b1);
        check("full_final", bus.blk_final, 1'b0);
        wait_idle();

        fill_msg(0, 8'h00, 0); send_msg(); wait_idle();
        fill_msg(0, 8'h00, 0); send_msg();
        fill_msg(3, 8'h00, 1); send_msg(); wait_idle();

        for (int m = 0; m < 25; m++) begin
            if ($urandom_range(0, 3) == 0) len = specials[$urandom_range(0, 11)];
            else len = $urandom_range(0, 150);
            fill_msg(len, 8'h00, 1);
            send_msg();
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        // Reset while the core holds the block; input stays valid through WAIT.
        hold_core   = 1;
        held_starts = 0;
        for (int k = 0; k < 64; k++) drive_beat(8'($urandom), 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hee;
        repeat (8) begin
            @(negedge clock);
            check("bp_in_ready", bus.in_ready, 1'b0);
        end
        check("abort_started", held_starts, 1);
        reset = 1'b0;
        #2;
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_blk_data", bus.blk_data, 512'd0);
        check("abort_blk_start", bus.blk_start, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset     = 1'b1;
        hold_core = 0;
        @(posedge clock);
        #1;
        fill_msg(10, 8'h00, 1);
        send_msg();
        wait_idle();

        check("msg_count", msgs_done, msgs_sent);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message front-end for the `sha256` compression core. It accepts a byte stream, applies FIPS 180-4 padding, and appends the 64-bit big-endian bit length. It then presents each 512-bit block to the core with a one-cycle `start` pulse and waits for the core's `finish` before building the next block. Multi-block messages and the extra length-only block are handled entirely here; the core only ever sees complete blocks.

## Interface
No parameters.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input byte/control qualifier
- `in_data`  in  8  message byte
- `in_last`  in  1  with `in_valid`: this beat ends the message
- `in_empty`  in  1  with `in_valid & in_last`: beat carries no byte (zero-length message); ignored otherwise
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `blk_data`  out  512  block to core; byte 0 in [511:504]; connects to core `block`
- `blk_start`  out  1  one-cycle pulse; connects to core `start`
- `blk_first`  out  1  valid with `blk_start`: first block of a message (core reloads H0..H7)
- `blk_final`  out  1  valid with `blk_start`: last block of a message
- `core_finish`  in  1  core `finish`; sampled only in WAIT
- `msg_done`  out  1  one-cycle pulse: final block's `core_finish` seen, digest valid

## Operation
- State: 64-byte buffer, `ptr[5:0]`, `bitlen[63:0]`, flags `first`, `pad_pend`, `len_pend`, `final`. FSM states: FILL, PAD, ISSUE, WAIT, LENBLK.
- FILL: `in_ready`=1. On an accepted byte: `buf[ptr]<=in_data`, `ptr++` (wraps 63→0), `bitlen+=8`.
  - If `ptr` was 63: go ISSUE (`final`=0). If `in_last` is also set, also set `pad_pend`.
  - Else if `in_last`: go PAD.
  - A beat with `in_empty` writes nothing and goes straight to PAD.
- PAD (one cycle): `buf[ptr]<=0x80`, bytes `ptr+1..63` <= 0.
  - If `ptr`≤55: bytes 56..63 <= `bitlen` big-endian, `final`=1.
  - Else: `len_pend`=1, `final`=0.
  - Go ISSUE.
- LENBLK (one cycle): all bytes <= 0, bytes 56..63 <= `bitlen`, `final`=1. Go ISSUE.
- ISSUE (one cycle): `blk_start`=1, `blk_first`=`first`, `blk_final`=`final`; then clear `first`. Go WAIT.
- WAIT: `in_ready`=0. `blk_data` is held stable from ISSUE until `core_finish`. On `core_finish`, in priority order:
  - `pad_pend`: clear it, go PAD.
  - `len_pend`: clear it, go LENBLK.
  - `final`: pulse `msg_done`; set `bitlen`=0, `ptr`=0, `first`=1; go FILL.
  - Otherwise: go FILL, continuing the same message.
- `bitlen` wraps mod 2^64. Messages are limited to < 2^61 bytes, so wrap is not a supported use case.
- `core_finish` outside WAIT is ignored.

## Timing
- Reset values: state FILL, `ptr`=0, `bitlen`=0, `first`=1, flags 0, buffer 0. Outputs: `in_ready`=1, `blk_data`=0, `blk_start`=0, `blk_first`=0, `blk_final`=0, `msg_done`=0.
- Reset mid-message (any state) discards the partial block and length. No `blk_start` or `msg_done` follows it.
- `blk_first`/`blk_final` are meaningful only while `blk_start`=1; otherwise they drive 0.
- `in_ready` is combinational from state only (FILL). It never depends on `in_valid`.
- Latency, accept of `in_last` byte with final `ptr`≤55 (after increment): PAD next cycle, `blk_start` the cycle after (2 cycles).
- Latency, full block (64th byte accepted): `blk_start` next cycle.
- After `core_finish`:
  - `in_ready` rises the next cycle (FILL), or
  - `blk_start` follows 2 cycles later (PAD/LENBLK → ISSUE).
- `msg_done` is asserted in the cycle after the final `core_finish` is sampled.
- At most one message is in flight. Input is backpressured for the full core latency.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block, `first`=`final`=1: word0 0x61626380, words1..14 0, word15 0x00000018; `msg_done` 1 cycle after `core_finish`.
- 55 bytes 0x00 -> single block: byte55=0x80, length 0x1B8, `final`=1.
- 56 bytes -> block1 has byte56=0x80 and `final`=0; after `core_finish`, block2 is all zero with length 0x1C0, `first`=0, `final`=1.
- 64 bytes -> block1 is the data with `final`=0; block2 is word0 0x80000000, length 0x200, `final`=1.
- Empty message (`in_last`,`in_empty`) -> one block: word0 0x80000000, rest 0, length 0; then a second message starts with `blk_first`=1 and `bitlen` restarted.
- Backpressure/reset:
  - `in_valid` held high through WAIT -> no byte accepted until FILL, no duplicates.
  - `reset` pulsed in WAIT -> `in_ready`=1, next message block contains only new bytes, `blk_first`=1.
